// File: rtl/rotate_pkg.sv
// Shared types and widths for the rotate/address generator.
package rotate_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  // One bit wider than hcount so raster minus offset stays a signed value
  localparam int unsigned COORD_W  = 12;

  typedef enum logic [1:0] {ROT0, ROT90, ROT180, ROT270} rot_mode_t;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               in_win;
  } coord_t;

endpackage

// File: rtl/rotate_coord_map.sv
// Combinational stage-1 map: window-relative (x, y) and rotation mode to source (row, col, in_win).
module rotate_coord_map
  import rotate_pkg::*;
#(
  parameter int unsigned SRC_W = 80,
  parameter int unsigned SRC_H = 107
) (
  input  logic signed [COORD_W-1:0] x,
  input  logic signed [COORD_W-1:0] y,
  input  rot_mode_t                 mode,
  output coord_t                    coord_c
);

  localparam logic signed [COORD_W-1:0] SW  = COORD_W'(SRC_W);
  localparam logic signed [COORD_W-1:0] SH  = COORD_W'(SRC_H);
  localparam logic signed [COORD_W-1:0] ONE = COORD_W'(1);

  logic signed [COORD_W-1:0] dw;
  logic signed [COORD_W-1:0] dh;
  logic signed [COORD_W-1:0] row;
  logic signed [COORD_W-1:0] col;

  // Quarter-turn modes swap the displayed width and height
  always_comb begin
    dw  = SW;
    dh  = SH;
    row = y;
    col = x;
    case (mode)
      ROT0: begin
        row = y;
        col = x;
      end
      ROT90: begin
        dw  = SH;
        dh  = SW;
        row = SH - ONE - x;
        col = y;
      end
      ROT180: begin
        row = SH - ONE - y;
        col = SW - ONE - x;
      end
      ROT270: begin
        dw  = SH;
        dh  = SW;
        row = x;
        col = SW - ONE - y;
      end
      default: begin
        row = y;
        col = x;
      end
    endcase
  end

  // Sign bits reject raster positions left of / above the image window
  assign coord_c.in_win = !x[COORD_W-1] && !y[COORD_W-1] && (x < dw) && (y < dh);
  assign coord_c.row    = $unsigned(row);
  assign coord_c.col    = $unsigned(col);

endmodule

// File: rtl/rotate_addr_gen.sv
// Three-stage pipelined raster-to-frame-buffer address generator with run-time 0/90/180/270 rotation.
module rotate_addr_gen
  import rotate_pkg::*;
#(
  parameter int unsigned SRC_W      = 80,
  parameter int unsigned SRC_H      = 107,
  parameter int unsigned H_OFFSET   = 0,
  parameter int unsigned V_OFFSET   = 0,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned PIX_W      = 1,
  parameter int unsigned RESET_MODE = 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic                data_valid_in,
  input  logic [PIX_W-1:0]    pixel_in,
  input  logic [1:0]          mode_in,
  output logic [PIX_W-1:0]    pixel_out,
  output logic [ADDR_W-1:0]   pixel_addr_out,
  output logic                data_valid_out,
  output logic [1:0]          mode_active_out
);

  localparam rot_mode_t         MODE_RST = rot_mode_t'(2'(RESET_MODE));
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  rot_mode_t                 active_mode;
  rot_mode_t                 eff_mode_c;
  logic                      frame_start_c;
  logic signed [COORD_W-1:0] x_c;
  logic signed [COORD_W-1:0] y_c;
  coord_t                    coord_c;

  coord_t                    s1_coord;
  logic                      s1_valid;
  logic [PIX_W-1:0]          s1_pix;

  logic [ADDR_W-1:0]         s2_prod;
  logic [COORD_W-1:0]        s2_col;
  logic                      s2_win;
  logic                      s2_valid;
  logic [PIX_W-1:0]          s2_pix;

  // A frame-start beat already uses the mode it latches
  assign frame_start_c = (hcount_in == '0) && (vcount_in == '0);
  assign eff_mode_c    = frame_start_c ? rot_mode_t'(mode_in) : active_mode;

  assign x_c = $signed({1'b0, hcount_in}) - $signed(COORD_W'(H_OFFSET));
  assign y_c = $signed({2'b00, vcount_in}) - $signed(COORD_W'(V_OFFSET));

  rotate_coord_map #(
    .SRC_W(SRC_W),
    .SRC_H(SRC_H)
  ) u_map (
    .x      (x_c),
    .y      (y_c),
    .mode   (eff_mode_c),
    .coord_c(coord_c)
  );

  // Mode register plus the three pipeline stages
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_mode    <= MODE_RST;
      s1_coord       <= '0;
      s1_valid       <= 1'b0;
      s1_pix         <= '0;
      s2_prod        <= '0;
      s2_col         <= '0;
      s2_win         <= 1'b0;
      s2_valid       <= 1'b0;
      s2_pix         <= '0;
      pixel_out      <= '0;
      pixel_addr_out <= '0;
      data_valid_out <= 1'b0;
    end else begin
      if (frame_start_c) begin
        active_mode <= rot_mode_t'(mode_in);
      end

      s1_coord <= coord_c;
      s1_valid <= data_valid_in;
      s1_pix   <= pixel_in;

      s2_prod  <= ADDR_W'(s1_coord.row) * STRIDE;
      s2_col   <= s1_coord.col;
      s2_win   <= s1_coord.in_win;
      s2_valid <= s1_valid;
      s2_pix   <= s1_pix;

      // Dropped beats present a zero address so nothing stale reaches the BRAM
      pixel_out      <= s2_pix;
      data_valid_out <= s2_valid && s2_win;
      pixel_addr_out <= (s2_valid && s2_win) ? (s2_prod + ADDR_W'(s2_col) + BASE) : '0;
    end
  end

  assign mode_active_out = active_mode;

endmodule

// File: tb/tb_rotate_addr_gen.sv
// Scoreboard bench for rotate_addr_gen: default instance plus an H_OFFSET=10 instance on shared inputs.
module tb_rotate_addr_gen;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned PIX_W  = 1;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [10:0]       hcount_in;
  logic [9:0]        vcount_in;
  logic              data_valid_in;
  logic [PIX_W-1:0]  pixel_in;
  logic [1:0]        mode_in;

  logic [PIX_W-1:0]  pixel_out,  pixel_out2;
  logic [ADDR_W-1:0] addr_out,   addr_out2;
  logic              valid_out,  valid_out2;
  logic [1:0]        mode_out,   mode_out2;

  rotate_addr_gen u_dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .pixel_in       (pixel_in),
    .mode_in        (mode_in),
    .pixel_out      (pixel_out),
    .pixel_addr_out (addr_out),
    .data_valid_out (valid_out),
    .mode_active_out(mode_out)
  );

  rotate_addr_gen #(.H_OFFSET(10)) u_off (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .pixel_in       (pixel_in),
    .mode_in        (mode_in),
    .pixel_out      (pixel_out2),
    .pixel_addr_out (addr_out2),
    .data_valid_out (valid_out2),
    .mode_active_out(mode_out2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int               addr;
    bit               valid;
    logic [PIX_W-1:0] pix;
    bit               chk2;
    int               addr2;
    bit               valid2;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] exp_mode;

  // Reference mapping for the default 80x107 source image
  function automatic void model(input int h, input int v, input int m, input int hoff,
                                output int a, output bit ok);
    int x, y, dw, dh, row, col;
    x = h - hoff;
    y = v;
    dw = (m == 1 || m == 3) ? 107 : 80;
    dh = (m == 1 || m == 3) ? 80 : 107;
    case (m)
      0:       begin row = y;       col = x;      end
      1:       begin row = 106 - x; col = y;      end
      2:       begin row = 106 - y; col = 79 - x; end
      default: begin row = x;       col = 79 - y; end
    endcase
    ok = (x >= 0) && (x < dw) && (y >= 0) && (y < dh);
    a  = ok ? row * 80 + col : 0;
  endfunction

  // One clock: check outputs of the beat driven three cycles ago, then drive a new beat
  task automatic step(input int h, input int v, input bit dv, input logic [PIX_W-1:0] pix,
                      input logic [1:0] m, input int ea, input bit ev,
                      input bit c2 = 1'b0, input int ea2 = 0, input bit ev2 = 1'b0);
    exp_t e;
    @(negedge clk_in);
    checks++;
    if (mode_out !== exp_mode) begin
      failures++;
      $display("FAIL mode_active: got %0d want %0d at %0t", mode_out, exp_mode, $time);
    end
    if (sb.size() == 3) begin
      e = sb.pop_front();
      checks++;
      if (valid_out !== e.valid) begin
        failures++;
        $display("FAIL data_valid: got %0b want %0b at %0t", valid_out, e.valid, $time);
      end
      checks++;
      if (addr_out !== ADDR_W'(e.addr)) begin
        failures++;
        $display("FAIL addr: got %0d want %0d at %0t", addr_out, e.addr, $time);
      end
      checks++;
      if (pixel_out !== e.pix) begin
        failures++;
        $display("FAIL pixel: got %0b want %0b at %0t", pixel_out, e.pix, $time);
      end
      if (e.chk2) begin
        checks++;
        if (valid_out2 !== e.valid2) begin
          failures++;
          $display("FAIL off_valid: got %0b want %0b at %0t", valid_out2, e.valid2, $time);
        end
        checks++;
        if (addr_out2 !== ADDR_W'(e.addr2)) begin
          failures++;
          $display("FAIL off_addr: got %0d want %0d at %0t", addr_out2, e.addr2, $time);
        end
      end
    end
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    data_valid_in = dv;
    pixel_in      = pix;
    mode_in       = m;
    if (h == 0 && v == 0) exp_mode = m;
    e = '{addr: ea, valid: ev, pix: pix, chk2: c2, addr2: ea2, valid2: ev2};
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    hcount_in     = 11'd500;
    vcount_in     = 10'd500;
    data_valid_in = 1'b0;
    pixel_in      = '0;
    mode_in       = 2'd0;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step(500, 500, 1'b0, '0, 2'd0, 0, 1'b0);
  endtask

  // Release reset with idle inputs; the pipeline then holds three empty beats
  task automatic release_reset();
    exp_t z;
    idle_inputs();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    sb.delete();
    z = '{addr: 0, valid: 1'b0, pix: '0, chk2: 1'b0, addr2: 0, valid2: 1'b0};
    for (int i = 0; i < 3; i++) sb.push_back(z);
    exp_mode = 2'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (valid_out !== 1'b0 || addr_out !== '0 || pixel_out !== '0) begin
      failures++;
      $display("FAIL %s_outputs: got valid=%0b addr=%0d pix=%0b want 0/0/0",
               tag, valid_out, addr_out, pixel_out);
    end
    checks++;
    if (mode_out !== 2'd1) begin
      failures++;
      $display("FAIL %s_mode: got %0d want 1", tag, mode_out);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_in = 1'b1;
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("reset");
    release_reset();
  endtask

  task automatic test_mode0();
    step(0, 0, 1'b1, 1'b1, 2'd0, 0, 1'b1);
    step(5, 2, 1'b1, 1'b0, 2'd0, 165, 1'b1);
    step(5, 2, 1'b1, 1'b1, 2'd0, 165, 1'b1);
    step(79, 106, 1'b1, 1'b1, 2'd0, 8559, 1'b1);
    step(80, 0, 1'b1, 1'b0, 2'd0, 0, 1'b0);
    flush();
  endtask

  task automatic test_mode1();
    step(0, 0, 1'b1, 1'b1, 2'd1, 8480, 1'b1);
    step(106, 79, 1'b1, 1'b0, 2'd1, 79, 1'b1);
    step(107, 0, 1'b1, 1'b1, 2'd1, 0, 1'b0);
    step(0, 80, 1'b1, 1'b1, 2'd1, 0, 1'b0);
    step(3, 3, 1'b0, 1'b1, 2'd1, 0, 1'b0);
    flush();
  endtask

  task automatic test_mode2_3();
    step(0, 0, 1'b1, 1'b1, 2'd2, 8559, 1'b1);
    step(0, 0, 1'b1, 1'b0, 2'd3, 79, 1'b1);
    step(106, 79, 1'b1, 1'b1, 2'd3, 8480, 1'b1);
    flush();
  endtask

  task automatic test_offset();
    step(0, 0, 1'b1, 1'b0, 2'd1, 8480, 1'b1, 1'b1, 0, 1'b0);
    step(9, 0, 1'b1, 1'b1, 2'd1, 7760, 1'b1, 1'b1, 0, 1'b0);
    step(10, 3, 1'b1, 1'b1, 2'd1, 7683, 1'b1, 1'b1, 8483, 1'b1);
    step(116, 0, 1'b1, 1'b0, 2'd1, 0, 1'b0, 1'b1, 0, 1'b1);
    step(117, 0, 1'b1, 1'b1, 2'd1, 0, 1'b0, 1'b1, 0, 1'b0);
    flush();
  endtask

  task automatic test_back_to_back();
    int h, v, a, a2;
    bit dv, ok, ok2;
    logic [1:0] m, em;
    logic [PIX_W-1:0] p;
    step(0, 0, 1'b1, 1'b1, 2'd1, 8480, 1'b1);
    for (int i = 0; i < 24; i++) begin
      h  = 95 + i;
      v  = (i * 7) % 90;
      dv = 1'($urandom_range(0, 3) != 0);
      p  = PIX_W'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      em = (h == 0 && v == 0) ? m : exp_mode;
      model(h, v, int'(em), 0, a, ok);
      model(h, v, int'(em), 10, a2, ok2);
      step(h, v, dv, p, m, (dv && ok) ? a : 0, dv && ok, 1'b1, (dv && ok2) ? a2 : 0, dv && ok2);
    end
    flush();
  endtask

  task automatic test_mode_change();
    step(0, 0, 1'b1, 1'b0, 2'd1, 8480, 1'b1);
    step(10, 5, 1'b1, 1'b1, 2'd2, 7685, 1'b1);
    step(20, 5, 1'b1, 1'b0, 2'd2, 6885, 1'b1);
    step(0, 0, 1'b1, 1'b1, 2'd2, 8559, 1'b1);
    step(5, 5, 1'b1, 1'b0, 2'd2, 8154, 1'b1);
    flush();
  endtask

  task automatic test_async_reset();
    step(0, 0, 1'b1, 1'b1, 2'd3, 79, 1'b1);
    step(1, 0, 1'b1, 1'b1, 2'd3, 159, 1'b1);
    step(2, 0, 1'b1, 1'b1, 2'd3, 239, 1'b1);
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("async_reset");
    release_reset();
    for (int i = 0; i < 4; i++) step(500, 500, 1'b0, '0, 2'd0, 0, 1'b0);
    step(0, 0, 1'b1, 1'b1, 2'd1, 8480, 1'b1);
    flush();
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_mode2_3();
    test_offset();
    test_back_to_back();
    test_mode_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rotate_addr_gen.md
Name: rotate_addr_gen

Overview:
- Parametrised, pipelined rotate/address generator for the camera/display path.
- Maps the display raster position (hcount_in, vcount_in) to a frame-buffer read address for a source image stored row-major.
- Supports 0/90/180/270-degree rotation, selectable at run time. The mode changes only at frame start.
- Sits between the video timing generator and the frame-buffer BRAM read port. It forwards pixel data and valid, delay-matched.

Parameters:
- SRC_W, 80, source image width in pixels (row stride in the frame buffer)
- SRC_H, 107, source image height in pixels
- H_OFFSET, 0, display hcount of the left edge of the rotated image
- V_OFFSET, 0, display vcount of the top edge of the rotated image
- BASE_ADDR, 0, frame-buffer base address added to every generated address
- ADDR_W, 17, address width
- PIX_W, 1, width of the pass-through pixel
- RESET_MODE, 1, rotation mode after reset (0=0deg, 1=90, 2=180, 3=270)

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- hcount_in  input  11  display column
- vcount_in  input  10  display row
- data_valid_in  input  1  input beat valid
- pixel_in  input  PIX_W  pixel travelling with the beat
- mode_in  input  2  requested rotation mode
- pixel_out  output  PIX_W  pixel delayed by 3 cycles
- pixel_addr_out  output  ADDR_W  frame-buffer read address
- data_valid_out  output  1  beat valid and inside the image window
- mode_active_out  output  2  rotation mode currently in effect

Behaviour:
- Reset and clocking:
  - One clock domain, clk_in. Reset is asynchronous, active-low (rst_n_in).
  - On reset, all pipeline registers and outputs go to 0, except active_mode, which takes RESET_MODE.
- Mode latching:
  - active_mode <= mode_in only on a cycle where hcount_in==0 and vcount_in==0. This is independent of data_valid_in.
  - That same beat already uses the new mode.
  - mode_in changes at any other time have no effect until the next frame start.
  - mode_active_out = active_mode.
- Stage 1:
  - x = hcount_in - H_OFFSET, y = vcount_in - V_OFFSET, computed signed, 12 bits.
  - Display dimensions: modes 0/2 use DW=SRC_W, DH=SRC_H; modes 1/3 use DW=SRC_H, DH=SRC_W.
  - in_win = (0<=x<DW) and (0<=y<DH).
  - Source coordinates: mode0 row=y, col=x; mode1 row=SRC_H-1-x, col=y; mode2 row=SRC_H-1-y, col=SRC_W-1-x; mode3 row=x, col=SRC_W-1-y.
  - Register row, col, in_win, data_valid_in, pixel_in.
- Stage 2: prod = row*SRC_W (registered multiply, ADDR_W bits); delay col, valid, pixel.
- Stage 3:
  - pixel_addr_out = prod + col + BASE_ADDR, truncated to ADDR_W.
  - data_valid_out = valid & in_win; pixel_out = pixel.
- Latency: exactly 3 cycles from input to outputs, for every beat. Fully pipelined, one beat per cycle, no stall.
- Out-of-window or invalid beats: data_valid_out=0 and pixel_addr_out=0. pixel_out is still the delayed pixel_in.
- Negative x/y (hcount below the offset) count as out-of-window. There must be no wrap-around into valid addresses.
- Reset asserted mid-operation: in-flight beats are discarded immediately. No stale valid beat appears after release.

Decomposition:
- Shared package rotate_pkg:
  - typedef enum rot_mode_t {ROT0, ROT90, ROT180, ROT270}.
  - Constants for the hcount/vcount widths (11/10).
- One natural sub-module: rotate_coord_map. It is combinational stage-1 logic mapping (x, y, mode) to (row, col, in_win). The top module holds all registers.

Test Plan:
- Mode 0, defaults, h=5 v=2 valid=1 -> 3 cycles later addr=165, data_valid_out=1, pixel_out=pixel_in.
- Mode 1 (reset default): h=0 v=0 -> addr=8480; h=106 v=79 -> addr=79; streamed back-to-back beats give one address per cycle.
- Mode 2 h=0 v=0 -> addr=8559. Mode 3 h=0 v=0 -> addr=79. Mode 3 h=106 v=79 -> addr=8480.
- Mode 1, h=107 v=0 or h=0 v=80, valid=1 -> data_valid_out=0, addr=0. With H_OFFSET=10, h=9 -> out-of-window.
- mode_in 1->2 at h=10 v=5 -> mode_active_out stays 1 and addresses stay mode 1. At the next h=0 v=0, mode_active_out=2 and that beat's addr=8559.
- Three valid beats in flight, then rst_n_in low asynchronously -> all outputs 0 without waiting for a clock edge, mode=RESET_MODE; after release, valid stays 0 until new input beats arrive.
